// File: rtl/mfcc_melbank_mac.sv
// -----------------------------------------------------------------------------
// mfcc_melbank_mac
//
// Consumes one frame of power-spectrum bins and forms a single mel filter
// energy: sum over bins of bin * coef[bin], where the coefficients come from
// an external melbank ROM addressed by the running bin index.
//
// Ports
//   clk        system clock (also clocks the ROM)
//   rst_n      asynchronous active-low reset
//   s_valid    spectrum bin valid
//   s_ready    block can accept a bin (high only in RUN)
//   s_data     spectrum bin value, unsigned
//   rom_addr   ROM address = current bin counter
//   rom_data   ROM read data, unsigned Q0.COEF_WIDTH coefficient
//   out_valid  filter energy valid (high only in DONE)
//   out_ready  downstream accepts the energy
//   out_data   filter energy = (sum >> COEF_WIDTH) reduced to OUT_WIDTH
//   out_sat    energy was clipped (only with saturation enabled)
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. A source holding valid while ready is low must keep its
// data stable; the block never drops valid-with-data once it is raised.
//
// Build option
//   MELBANK_MAC_SAT_EN  defined: clip out_data to all-ones and flag out_sat
//                       when the shifted sum does not fit in OUT_WIDTH.
//                       undefined: keep the low OUT_WIDTH bits, out_sat = 0.
// -----------------------------------------------------------------------------
module mfcc_melbank_mac #(
  parameter int ADDR_WIDTH = 9,
  parameter int COEF_WIDTH = 8,
  parameter int DIN_WIDTH  = 16,
  parameter int NBIN       = 257,
  parameter int ROM_LAT    = 1,
  parameter int OUT_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DIN_WIDTH-1:0]  s_data,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [COEF_WIDTH-1:0] rom_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_sat
);

  // Wide enough that NBIN full-scale products can never overflow.
  localparam int ACC_WIDTH  = DIN_WIDTH + COEF_WIDTH + ADDR_WIDTH;
  localparam int PROD_WIDTH = DIN_WIDTH + COEF_WIDTH;
  localparam int SH_WIDTH   = DIN_WIDTH + ADDR_WIDTH;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   bin_cnt_q, bin_cnt_d;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic                    out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]    out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;

  // Bin delay line: matches the ROM read latency so each bin meets the
  // coefficient fetched for its own address. l_q tags the frame's last bin.
  logic [DIN_WIDTH-1:0]    d_q [ROM_LAT];
  logic [ROM_LAT-1:0]      v_q;
  logic [ROM_LAT-1:0]      l_q;

  logic                    accept;
  logic                    last_bin;
  logic                    exit_v;
  logic                    exit_l;
  logic [PROD_WIDTH-1:0]   prod;
  logic [ACC_WIDTH-1:0]    acc_mac;
  logic [SH_WIDTH-1:0]     sh;
  logic [OUT_WIDTH-1:0]    res;
  logic                    res_sat;

  assign s_ready   = (state_q == RUN);
  assign rom_addr  = bin_cnt_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  assign accept   = s_valid && s_ready;
  assign last_bin = (bin_cnt_q == ADDR_WIDTH'(NBIN - 1));
  assign exit_v   = v_q[ROM_LAT-1];
  assign exit_l   = l_q[ROM_LAT-1];

  assign prod    = PROD_WIDTH'(d_q[ROM_LAT-1]) * PROD_WIDTH'(rom_data);
  // Sum including this cycle's MAC, so the final result can be captured on
  // the same edge that registers the last product.
  assign acc_mac = acc_q + (exit_v ? ACC_WIDTH'(prod) : '0);
  assign sh      = SH_WIDTH'(acc_mac >> COEF_WIDTH);

`ifdef MELBANK_MAC_SAT_EN
  always_comb begin
    res_sat = 1'b0;
    res     = OUT_WIDTH'(sh);
    if ((SH_WIDTH > OUT_WIDTH) && ((sh >> OUT_WIDTH) != '0)) begin
      res_sat = 1'b1;
      res     = '1;
    end
  end
`else
  assign res     = OUT_WIDTH'(sh);
  assign res_sat = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    bin_cnt_d   = bin_cnt_q;
    acc_d       = acc_mac;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    if (accept) begin
      bin_cnt_d = last_bin ? '0 : bin_cnt_q + 1'b1;
    end

    case (state_q)
      RUN: begin
        if (accept && last_bin) state_d = FLUSH;
      end
      FLUSH: begin
        // Last tagged bin leaves the delay line: its MAC lands in acc now.
        if (exit_v && exit_l) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_data_d  = res;
          out_sat_d   = res_sat;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = RUN;
          out_valid_d = 1'b0;
          acc_d       = '0;
        end
      end
      default: begin
        state_d     = RUN;
        out_valid_d = 1'b0;
        acc_d       = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      bin_cnt_q   <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_cnt_q   <= bin_cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROM_LAT; i++) d_q[i] <= '0;
      v_q <= '0;
      l_q <= '0;
    end else begin
      d_q[0] <= s_data;
      v_q[0] <= accept;
      l_q[0] <= accept && last_bin;
      for (int i = 1; i < ROM_LAT; i++) begin
        d_q[i] <= d_q[i-1];
        v_q[i] <= v_q[i-1];
        l_q[i] <= l_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_mfcc_melbank_mac.sv
// -----------------------------------------------------------------------------
// tb_mfcc_melbank_mac
//
// Three instances share one stimulus path, selected by sel:
//   0: NBIN=4,   ROM_LAT=1, OUT_WIDTH=8  (also the clipping / wrap case)
//   1: NBIN=4,   ROM_LAT=2, OUT_WIDTH=24 (registered-output ROM model)
//   2: NBIN=257, ROM_LAT=1, OUT_WIDTH=24
// All three ROM models read the same coefficient table rom[].
// -----------------------------------------------------------------------------
module tb_mfcc_melbank_mac;

  localparam int AW = 9;
  localparam int CW = 8;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [1:0]    sel;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          out_ready;

  logic [CW-1:0] rom [512];

  logic [2:0]    sv, sr, ov, os;
  logic [AW-1:0] ra0, ra1, ra2;
  logic [CW-1:0] rd0, rd1, rd1_p, rd2;
  logic [7:0]    od0;
  logic [23:0]   od1, od2;

  assign sv[0] = s_valid && (sel == 2'd0);
  assign sv[1] = s_valid && (sel == 2'd1);
  assign sv[2] = s_valid && (sel == 2'd2);

  always @(posedge clk) begin
    rd0   <= rom[ra0];
    rd1_p <= rom[ra1];
    rd1   <= rd1_p;
    rd2   <= rom[ra2];
  end

  mfcc_melbank_mac #(.ADDR_WIDTH(AW), .COEF_WIDTH(CW), .DIN_WIDTH(DW),
    .NBIN(4), .ROM_LAT(1), .OUT_WIDTH(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .s_valid(sv[0]), .s_ready(sr[0]), .s_data(s_data),
    .rom_addr(ra0), .rom_data(rd0), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od0), .out_sat(os[0]));

  mfcc_melbank_mac #(.ADDR_WIDTH(AW), .COEF_WIDTH(CW), .DIN_WIDTH(DW),
    .NBIN(4), .ROM_LAT(2), .OUT_WIDTH(24)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .s_valid(sv[1]), .s_ready(sr[1]), .s_data(s_data),
    .rom_addr(ra1), .rom_data(rd1), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od1), .out_sat(os[1]));

  mfcc_melbank_mac #(.ADDR_WIDTH(AW), .COEF_WIDTH(CW), .DIN_WIDTH(DW),
    .NBIN(257), .ROM_LAT(1), .OUT_WIDTH(24)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .s_valid(sv[2]), .s_ready(sr[2]), .s_data(s_data),
    .rom_addr(ra2), .rom_data(rd2), .out_valid(ov[2]), .out_ready(out_ready),
    .out_data(od2), .out_sat(os[2]));

  // Selected-instance view.
  logic          m_ready, m_valid, m_sat;
  logic [AW-1:0] m_addr;
  logic [23:0]   m_data;

  always_comb begin
    m_ready = sr[0];
    m_valid = ov[0];
    m_sat   = os[0];
    m_addr  = ra0;
    m_data  = {16'd0, od0};
    case (sel)
      2'd1: begin
        m_ready = sr[1]; m_valid = ov[1]; m_sat = os[1]; m_addr = ra1; m_data = od1;
      end
      2'd2: begin
        m_ready = sr[2]; m_valid = ov[2]; m_sat = os[2]; m_addr = ra2; m_data = od2;
      end
      default: ;
    endcase
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act);
    logic [31:0] e;
    e = exp_q.pop_front();
    n_cmp++;
    if (act !== e) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, e, $time);
    end
  endtask

  task automatic expect_eq(input string name, input logic [31:0] act,
                           input logic [31:0] e);
    exp_q.push_back(e);
    chk(name, act);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_rom(input int mode);
    for (int k = 0; k < 512; k++) begin
      case (mode)
        0:       rom[k] = 8'(k);
        1:       rom[k] = 8'd255;
        default: rom[k] = 8'd0;
      endcase
    end
  endtask

  task automatic check_reset_values();
    expect_eq("rst_s_ready",   32'(m_ready), 32'd1);
    expect_eq("rst_out_valid", 32'(m_valid), 32'd0);
    expect_eq("rst_out_data",  m_data,       32'd0);
    expect_eq("rst_out_sat",   32'(m_sat),   32'd0);
    expect_eq("rst_rom_addr",  32'(m_addr),  32'd0);
  endtask

  // Send nbin bins (optionally with random gaps), then check out_valid
  // appears exactly lat edges after the last accepting edge.
  task automatic run_frame(input int nbin, input int lat,
                           input logic [DW-1:0] data, input bit gaps);
    int t;
    for (int k = 0; k < nbin; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          s_valid = 1'b0;
          step();
        end
      end
      s_valid = 1'b1;
      s_data  = data;
      t = 0;
      while (!m_ready && t < 50) begin
        step();
        t++;
      end
      if (!m_ready) expect_eq("s_ready_timeout", 32'(m_ready), 32'd1);
      if (k < 4 || k == nbin - 1) expect_eq("rom_addr_step", 32'(m_addr), 32'(k));
      step();
    end
    s_valid = 1'b0;
    expect_eq("flush_out_valid", 32'(m_valid), 32'd0);
    expect_eq("flush_s_ready",   32'(m_ready), 32'd0);
    for (int e = 1; e <= lat; e++) begin
      step();
      expect_eq("out_valid_latency", 32'(m_valid), (e == lat) ? 32'd1 : 32'd0);
      expect_eq("busy_s_ready",      32'(m_ready), 32'd0);
    end
  endtask

  // Stall with out_ready low while s_valid wiggles, then handshake with
  // s_valid already high for the next frame.
  task automatic finish_frame(input int hold, input logic [23:0] ed, input logic es);
    expect_eq("out_data", m_data,      32'(ed));
    expect_eq("out_sat",  32'(m_sat),  32'(es));
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      s_valid   = 1'b1;
      s_data    = DW'($urandom);
      step();
      expect_eq("stall_out_valid", 32'(m_valid), 32'd1);
      expect_eq("stall_out_data",  m_data,       32'(ed));
      expect_eq("stall_s_ready",   32'(m_ready), 32'd0);
      expect_eq("stall_rom_addr",  32'(m_addr),  32'd0);
    end
    out_ready = 1'b1;
    s_valid   = 1'b1;
    step();
    out_ready = 1'b0;
    expect_eq("hs_out_valid", 32'(m_valid), 32'd0);
    expect_eq("hs_s_ready",   32'(m_ready), 32'd1);
    expect_eq("hs_no_accept", 32'(m_addr),  32'd0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int          inst;
    int          nbin;
    int          lat;
    logic [15:0] data;
    int          coef_mode;  // 0: coef=k[7:0], 1: coef=255, 2: coef=0
    bit          gaps;
    int          hold;
    logic [23:0] exp_data;
    logic        exp_sat;
  } vec_t;

  vec_t vecs [8];

`ifdef MELBANK_MAC_SAT_EN
  localparam logic [23:0] CLIP_D = 24'd255;
  localparam logic        CLIP_S = 1'b1;
`else
  localparam logic [23:0] CLIP_D = 24'hFC;  // low 8 bits of 66845700>>8 = 0x3FBFC
  localparam logic        CLIP_S = 1'b0;
`endif

  initial begin
    // 256*(0+1+2+3)>>8 = 6 ; 300*6=1800>>8 = 7 ; 256*32640>>8 = 32640
    // 257*1000*255 = 65535000, >>8 = 255996
    vecs[0] = '{0,   4, 1, 16'd256,   0, 1'b0,  2, 24'd6,      1'b0};
    vecs[1] = '{0,   4, 1, 16'd256,   0, 1'b0,  0, 24'd6,      1'b0};
    vecs[2] = '{1,   4, 2, 16'd256,   0, 1'b1,  3, 24'd6,      1'b0};
    vecs[3] = '{1,   4, 2, 16'd300,   0, 1'b1,  1, 24'd7,      1'b0};
    vecs[4] = '{1,   4, 2, 16'd1000,  2, 1'b0,  1, 24'd0,      1'b0};
    vecs[5] = '{2, 257, 1, 16'd256,   0, 1'b0, 20, 24'd32640,  1'b0};
    vecs[6] = '{2, 257, 1, 16'd1000,  1, 1'b1,  1, 24'd255996, 1'b0};
    vecs[7] = '{0,   4, 1, 16'd65535, 1, 1'b0,  2, CLIP_D,     CLIP_S};

    rst_n     = 1'b0;
    sel       = 2'd0;
    s_valid   = 1'b0;
    s_data    = '0;
    out_ready = 1'b0;
    load_rom(0);
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      sel = 2'(i);
      #1;
      check_reset_values();
    end
    rst_n = 1'b1;
    sel   = 2'd0;
    step();

    for (int v = 0; v < 8; v++) begin
      sel = 2'(vecs[v].inst);
      load_rom(vecs[v].coef_mode);
      run_frame(vecs[v].nbin, vecs[v].lat, vecs[v].data, vecs[v].gaps);
      finish_frame(vecs[v].hold, vecs[v].exp_data, vecs[v].exp_sat);
    end

    // Reset mid-frame after bins 0..2 of 4, then a clean full frame.
    s_valid = 1'b0;
    sel     = 2'd0;
    load_rom(0);
    step();
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1;
      s_data  = 16'd256;
      step();
    end
    s_valid = 1'b0;
    expect_eq("mid_rom_addr", 32'(m_addr), 32'd3);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    #2;
    rst_n = 1'b1;
    step();
    run_frame(4, 1, 16'd256, 1'b0);
    finish_frame(1, 24'd6, 1'b0);

    // Reset while DONE holds a nonzero result on the ROM_LAT=2 instance.
    s_valid = 1'b0;
    sel     = 2'd1;
    step();
    run_frame(4, 2, 16'd256, 1'b0);
    expect_eq("done_before_rst", m_data, 32'd6);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    #2;
    rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mfcc_melbank_mac.md
Name: mfcc_melbank_mac

Overview:
Consumer end of the melbank coefficient ROM read interface. Accepts a streamed power spectrum for one frame, one bin per handshake, and drives the ROM address with the current bin index. Each returned coefficient is multiplied with its bin and summed into one filter energy. Sits between the FFT power stage and the log/DCT stage, with one instance per melbank ROM.

Parameters:
ADDR_WIDTH, 9, ROM address width; must satisfy NBIN <= 2**ADDR_WIDTH.
COEF_WIDTH, 8, ROM data width; coefficient is unsigned Q0.COEF_WIDTH.
DIN_WIDTH, 16, unsigned power-spectrum bin width.
NBIN, 257, bins per frame.
ROM_LAT, 1, ROM read latency in clocks: 1 for OUT_REG=0, 2 for OUT_REG=1. Only 1 and 2 are legal.
OUT_WIDTH, 24, energy output width.

Ports:
clk  in  1  system clock; also clocks the ROM.
rst_n  in  1  asynchronous active-low reset.
s_valid  in  1  spectrum bin valid.
s_ready  out  1  block can accept a bin.
s_data  in  DIN_WIDTH  spectrum bin value.
rom_addr  out  ADDR_WIDTH  ROM address; connects to ROM addr.
rom_data  in  COEF_WIDTH  ROM read data; connects to ROM rd_data.
out_valid  out  1  filter energy valid.
out_ready  in  1  downstream accepts the energy.
out_data  out  OUT_WIDTH  filter energy.
out_sat  out  1  energy was clipped (see Optional Feature).

Behaviour:
- Accumulator width: ACC_WIDTH = DIN_WIDTH + COEF_WIDTH + ADDR_WIDTH, so the sum cannot overflow.
- States: RUN, FLUSH, DONE. Reset state is RUN.
- Reset values: s_ready=1, out_valid=0, out_data=0, out_sat=0, rom_addr=0, bin_cnt=0, acc=0, MAC pipeline empty.
- rom_addr = bin_cnt, combinational from the counter. It is stable whenever no accept occurs.
- s_ready = (state==RUN).
- Accept = s_valid && s_ready. On the accept edge, s_data enters a ROM_LAT-deep delay line tagged valid, and bin_cnt increments.
- When a tagged bin exits the delay line, it lines up with rom_data for its own address. On that edge, acc += d_q * rom_data (unsigned).
- No bubbles: back-to-back accepts give one MAC per clock. Gaps in s_valid insert bubbles only; the sum is unaffected.
- RUN -> FLUSH on accept of bin NBIN-1. bin_cnt wraps to 0 on that accept.
- FLUSH lasts until the last MAC is registered. out_valid rises exactly ROM_LAT clock edges after the accepting edge of bin NBIN-1, and state becomes DONE.
- DONE: out_valid=1. out_data = acc >> COEF_WIDTH, reduced to OUT_WIDTH. out_data and out_sat hold until out_valid && out_ready.
- Handshake edge in DONE: out_valid drops, acc clears to 0, state returns to RUN, s_ready rises on the next cycle.
- Because s_ready is low in DONE, bin 0 of the next frame cannot be accepted on the same edge as the handshake.
- s_valid asserted while s_ready=0: no accept; the source must hold s_data.
- out_ready low in DONE: the block stalls indefinitely with no data loss.
- rst_n low at any time (mid-frame, in FLUSH, or in DONE) immediately forces all reset values. The partial frame is discarded, and the next accepted bin is bin 0.
- A frame with all-zero coefficients gives out_data=0.

Optional Feature:
MELBANK_MAC_SAT_EN
- Defined: if (acc >> COEF_WIDTH) >= 2**OUT_WIDTH, out_data = 2**OUT_WIDTH-1 and out_sat=1. Otherwise the value passes through and out_sat=0. out_sat is valid with out_valid.
- Not defined: out_data keeps the low OUT_WIDTH bits of (acc >> COEF_WIDTH) (wrap), and out_sat is tied 0.

Test Plan:
- NBIN=4, ROM_LAT=1, ROM coef[k]=k, s_data=256 each bin, back-to-back -> rom_addr steps 0,1,2,3 on consecutive cycles; out_valid rises 1 edge after the bin-3 accept; out_data=6.
- Same stream with ROM_LAT=2 (registered ROM model) and random s_valid gaps -> out_data=6; out_valid rises 2 edges after the bin-3 accept; s_ready=0 throughout FLUSH/DONE.
- NBIN=257, coef[k]=k[7:0], s_data=256 each bin, out_ready held low 20 cycles -> out_data=32640+0+...+0 (bins 256 give coef 0) = 32640; value and out_valid stable for all 20 cycles; s_valid ignored.
- Handshake then immediate next frame: out_ready=1 in DONE with s_valid=1 -> no accept on that edge; bin 0 accepted next edge; second frame result equals first (acc was cleared).
- rst_n pulsed low mid-frame after bin 2 of 4 -> all outputs return to reset values at once; a following full frame gives the correct full sum.
- OUT_WIDTH=8, s_data=65535, coef=255 for all bins, NBIN=4 -> with MELBANK_MAC_SAT_EN: out_data=255, out_sat=1; without: out_data = low 8 bits of (4*65535*255)>>8 = 0xFC, out_sat=0.
